// File: rtl/apb_uart_arbiter.sv
`default_nettype none
// ============================================================================
// apb_uart_arbiter : two-requester round-robin arbiter driving one APB master
// Rev 1.0
// ============================================================================
module apb_uart_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic [1:0]        grant
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            owner;
  logic            last;
  logic [CW-1:0]   wait_cnt;
  logic [1:0]      eligible;
  logic            pick;
  logic            timed_out;
  logic            finish;

  // A requester whose done pulse is out this cycle is masked so its held req is not re-served.
  assign eligible  = {req1 & ~done1, req0 & ~done0};
  assign pick      = (eligible == 2'b10) | ((eligible == 2'b11) & ~last);
  assign timed_out = (TIMEOUT > 0) && !PREADY && (wait_cnt == CW'(TIMEOUT - 1));
  assign finish    = (state == ACCESS) && (PREADY || timed_out);

  assign PSEL    = (state != IDLE);
  assign PENABLE = (state == ACCESS);
  assign grant   = PSEL ? (owner ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|eligible) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      owner    <= 1'b0;
      last     <= 1'b1;
      wait_cnt <= '0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      err0     <= 1'b0;
      err1     <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      if (state == IDLE && |eligible) begin
        owner  <= pick;
        PWRITE <= pick ? wr1    : wr0;
        PADDR  <= pick ? addr1  : addr0;
        PWDATA <= pick ? wdata1 : wdata0;
      end
      if (state == ACCESS) begin
        if (finish) begin
          wait_cnt <= '0;
          last     <= owner;
          if (owner) begin
            done1 <= 1'b1;
            err1  <= timed_out | PSLVERR;
            if (PREADY && !PSLVERR && !PWRITE) rdata1 <= PRDATA;
          end else begin
            done0 <= 1'b1;
            err0  <= timed_out | PSLVERR;
            if (PREADY && !PSLVERR && !PWRITE) rdata0 <= PRDATA;
          end
        end else begin
          wait_cnt <= wait_cnt + CW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_uart_arbiter.sv
`default_nettype none
// Bench for apb_uart_arbiter: directed scenarios plus randomized transfers
// checked against a transaction-level model (round-robin, latency, error rules).
module tb_apb_uart_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic              req0, wr0, req1, wr1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              done0, err0, done1, err1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              PSEL, PENABLE, PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic [1:0]        grant;

  int n_checks = 0;
  int n_fail   = 0;

  // slave behaviour knobs
  int                stall_n   = 0;
  logic              slv_err   = 1'b0;
  logic [DATA_W-1:0] slv_rdata = '0;
  int                acc       = 0;

  // transaction-level model
  bit                exp_last = 1'b1;
  logic [DATA_W-1:0] exp_rdata [2];
  logic              rq_wr     [2];
  logic [ADDR_W-1:0] rq_addr   [2];
  logic [DATA_W-1:0] rq_wdata  [2];

  apb_uart_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .done0(done0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .done1(done1), .err1(err1), .rdata1(rdata1),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .grant(grant)
  );

  always #5 PCLK = ~PCLK;

  // APB slave: stall_n wait states per transfer, then ready
  always @(posedge PCLK) begin
    #2;
    if (PSEL && PENABLE) begin
      PREADY = (acc >= stall_n);
      acc    = acc + 1;
    end else begin
      PREADY = 1'b0;
      acc    = 0;
    end
    PRDATA  = slv_rdata;
    PSLVERR = slv_err;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  function automatic int rr_pick(input logic [1:0] pend);
    if (pend == 2'b01) return 0;
    if (pend == 2'b10) return 1;
    return exp_last ? 0 : 1;
  endfunction

  function automatic int exp_lat(input int stall);
    return 2 + ((TIMEOUT > 0 && stall >= TIMEOUT) ? TIMEOUT : stall + 1);
  endfunction

  task automatic set_cmd(input int i, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    rq_wr[i] = w; rq_addr[i] = a; rq_wdata[i] = d;
  endtask

  task automatic drive_req(input int i, input logic on);
    if (i == 0) begin
      req0 = on; wr0 = rq_wr[0]; addr0 = rq_addr[0]; wdata0 = rq_wdata[0];
    end else begin
      req1 = on; wr1 = rq_wr[1]; addr1 = rq_addr[1]; wdata1 = rq_wdata[1];
    end
  endtask

  task automatic slave_cfg(input int st, input logic e, input logic [DATA_W-1:0] rd);
    stall_n = st; slv_err = e; slv_rdata = rd;
  endtask

  // Advances until a done pulse (or budget), recording what the bus showed.
  task automatic wait_done(output int lat, output logic [1:0] dn, output logic [1:0] er,
                           output logic [1:0] gr, output logic [ADDR_W-1:0] a,
                           output logic [DATA_W-1:0] wd, output logic w,
                           output logic stable, output logic glitch);
    bit seen;
    lat = -1; dn = '0; er = '0; gr = '0; a = '0; wd = '0; w = 1'b0;
    stable = 1'b1; glitch = 1'b0; seen = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if ((err0 && !done0) || (err1 && !done1)) glitch = 1'b1;
      if (PSEL) begin
        if (!seen) begin
          seen = 1'b1; gr = grant; a = PADDR; wd = PWDATA; w = PWRITE;
        end else if (PADDR !== a || PWDATA !== wd || PWRITE !== w || grant !== gr) begin
          stable = 1'b0;
        end
      end
      if (done0 || done1) begin
        lat = c; dn = {done1, done0}; er = {err1, err0};
        break;
      end
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) tick();
    n_checks++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000", {PSEL, PENABLE, PWRITE}); end
    n_checks++; if (PADDR !== '0 || PWDATA !== '0) begin n_fail++; $display("FAIL reset_bus: got addr %h data %h expected 0", PADDR, PWDATA); end
    n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b expected 00", grant); end
    n_checks++; if ({done1, done0, err1, err0} !== 4'b0000) begin n_fail++; $display("FAIL reset_done_err: got %b expected 0000", {done1, done0, err1, err0}); end
    n_checks++; if (rdata0 !== '0 || rdata1 !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h %h expected 0", rdata0, rdata1); end
    PRESET = 1'b0;
    exp_last = 1'b1; exp_rdata[0] = '0; exp_rdata[1] = '0;
    tick();
  endtask

  task automatic test_tie();
    int lat, w; logic [1:0] dn, er, gr; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] wd;
    logic pw, st, gl; logic [DATA_W-1:0] rd;
    set_cmd(0, 1'b0, $urandom, $urandom);
    set_cmd(1, 1'b0, $urandom, $urandom);
    for (int k = 0; k < 3; k++) begin
      if (k == 0 || k == 2) begin drive_req(0, 1'b1); drive_req(1, 1'b1); end
      rd = $urandom; slave_cfg(0, 1'b0, rd);
      w = rr_pick({req1, req0});
      exp_rdata[w] = rd;
      wait_done(lat, dn, er, gr, a, wd, pw, st, gl);
      n_checks++; if (dn !== 2'(1 << w)) begin n_fail++; $display("FAIL tie_winner_%0d: got done %b expected %b", k, dn, 2'(1 << w)); end
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL tie_latency_%0d: got %0d expected 3", k, lat); end
      n_checks++; if (a !== rq_addr[w] || gr !== 2'(1 << w)) begin n_fail++; $display("FAIL tie_bus_%0d: got addr %h grant %b expected %h %b", k, a, gr, rq_addr[w], 2'(1 << w)); end
      n_checks++; if (rdata0 !== exp_rdata[0] || rdata1 !== exp_rdata[1]) begin n_fail++; $display("FAIL tie_rdata_%0d: got %h %h expected %h %h", k, rdata0, rdata1, exp_rdata[0], exp_rdata[1]); end
      exp_last = (w == 1);
      drive_req(w, 1'b0);
      if (k == 1) tick();
    end
    drive_req(0, 1'b0); drive_req(1, 1'b0);
    tick();
  endtask

  task automatic test_single_read();
    int lat; logic [1:0] dn, er, gr; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] wd;
    logic pw, st, gl;
    set_cmd(0, 1'b0, 32'h10, $urandom);
    slave_cfg(0, 1'b0, 32'hDEADBEEF);
    drive_req(0, 1'b1);
    wait_done(lat, dn, er, gr, a, wd, pw, st, gl);
    n_checks++; if (lat !== 3 || dn !== 2'b01) begin n_fail++; $display("FAIL single_read_done: got lat %0d done %b expected 3 01", lat, dn); end
    n_checks++; if (er !== 2'b00) begin n_fail++; $display("FAIL single_read_err: got %b expected 00", er); end
    n_checks++; if (rdata0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_read_rdata: got %h expected deadbeef", rdata0); end
    n_checks++; if (a !== 32'h10 || pw !== 1'b0 || gr !== 2'b01) begin n_fail++; $display("FAIL single_read_bus: got addr %h wr %b grant %b expected 10 0 01", a, pw, gr); end
    exp_rdata[0] = 32'hDEADBEEF; exp_last = 1'b0;
    drive_req(0, 1'b0);
    tick();
  endtask

  task automatic test_wait_states();
    int lat; logic [1:0] dn, er, gr; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] wd;
    logic pw, st, gl;
    set_cmd(1, 1'b1, $urandom, 32'h55);
    slave_cfg(TIMEOUT - 1, 1'b0, $urandom);
    drive_req(1, 1'b1);
    wait_done(lat, dn, er, gr, a, wd, pw, st, gl);
    n_checks++; if (lat !== exp_lat(TIMEOUT - 1) || dn !== 2'b10) begin n_fail++; $display("FAIL wait_done: got lat %0d done %b expected %0d 10", lat, dn, exp_lat(TIMEOUT - 1)); end
    n_checks++; if (er !== 2'b00) begin n_fail++; $display("FAIL wait_err: got %b expected 00", er); end
    n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL wait_stable: got %b expected 1", st); end
    n_checks++; if (wd !== 32'h55 || a !== rq_addr[1] || pw !== 1'b1) begin n_fail++; $display("FAIL wait_bus: got data %h addr %h wr %b expected 55 %h 1", wd, a, pw, rq_addr[1]); end
    n_checks++; if (rdata1 !== exp_rdata[1]) begin n_fail++; $display("FAIL wait_rdata: got %h expected %h", rdata1, exp_rdata[1]); end
    exp_last = 1'b1;
    drive_req(1, 1'b0);
    tick();
  endtask

  task automatic test_timeout();
    int lat; logic [1:0] dn, er, gr; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] wd;
    logic pw, st, gl;
    set_cmd(0, 1'b0, $urandom, $urandom);
    slave_cfg(1000, 1'b0, ~exp_rdata[0]);
    drive_req(0, 1'b1);
    wait_done(lat, dn, er, gr, a, wd, pw, st, gl);
    n_checks++; if (lat !== 2 + TIMEOUT || dn !== 2'b01) begin n_fail++; $display("FAIL timeout_done: got lat %0d done %b expected %0d 01", lat, dn, 2 + TIMEOUT); end
    n_checks++; if (er !== 2'b01) begin n_fail++; $display("FAIL timeout_err: got %b expected 01", er); end
    n_checks++; if (rdata0 !== exp_rdata[0]) begin n_fail++; $display("FAIL timeout_rdata: got %h expected %h", rdata0, exp_rdata[0]); end
    n_checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin n_fail++; $display("FAIL timeout_psel: got %b%b expected 00", PSEL, PENABLE); end
    exp_last = 1'b0;
    drive_req(0, 1'b0);
    tick();
  endtask

  task automatic test_slave_error();
    int lat; logic [1:0] dn, er, gr; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] wd;
    logic pw, st, gl;
    set_cmd(1, 1'b0, $urandom, $urandom);
    slave_cfg(1, 1'b1, ~exp_rdata[1]);
    drive_req(1, 1'b1);
    wait_done(lat, dn, er, gr, a, wd, pw, st, gl);
    n_checks++; if (lat !== exp_lat(1) || dn !== 2'b10) begin n_fail++; $display("FAIL slverr_done: got lat %0d done %b expected %0d 10", lat, dn, exp_lat(1)); end
    n_checks++; if (er !== 2'b10) begin n_fail++; $display("FAIL slverr_err: got %b expected 10", er); end
    n_checks++; if (rdata1 !== exp_rdata[1]) begin n_fail++; $display("FAIL slverr_rdata: got %h expected %h", rdata1, exp_rdata[1]); end
    exp_last = 1'b1;
    drive_req(1, 1'b0);
    slave_cfg(0, 1'b0, '0);
    tick();
  endtask

  task automatic test_random();
    int lat, w, st_n; logic [1:0] dn, er, gr, pend, exp_er; logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd; logic pw, st, gl, e;
    for (int r = 0; r < 30; r++) begin
      pend = 2'($urandom_range(1, 3));
      slave_cfg($urandom_range(0, 5), ($urandom_range(0, 3) == 0), $urandom);
      for (int i = 0; i < 2; i++) begin
        set_cmd(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
        drive_req(i, pend[i]);
      end
      while (pend != 2'b00) begin
        w = rr_pick(pend);
        st_n = stall_n;
        e = (st_n >= TIMEOUT) || slv_err;
        exp_er = e ? 2'(1 << w) : 2'b00;
        if (!rq_wr[w] && !e) exp_rdata[w] = slv_rdata;
        wait_done(lat, dn, er, gr, a, wd, pw, st, gl);
        n_checks++; if (dn !== 2'(1 << w)) begin n_fail++; $display("FAIL rnd_winner r%0d: got done %b expected %b", r, dn, 2'(1 << w)); end
        n_checks++; if (lat !== exp_lat(st_n)) begin n_fail++; $display("FAIL rnd_latency r%0d: got %0d expected %0d", r, lat, exp_lat(st_n)); end
        n_checks++; if (er !== exp_er) begin n_fail++; $display("FAIL rnd_err r%0d: got %b expected %b", r, er, exp_er); end
        n_checks++; if (rdata0 !== exp_rdata[0] || rdata1 !== exp_rdata[1]) begin n_fail++; $display("FAIL rnd_rdata r%0d: got %h %h expected %h %h", r, rdata0, rdata1, exp_rdata[0], exp_rdata[1]); end
        n_checks++; if (a !== rq_addr[w] || wd !== rq_wdata[w] || pw !== rq_wr[w] || gr !== 2'(1 << w)) begin n_fail++; $display("FAIL rnd_bus r%0d: got %h %h %b %b expected %h %h %b %b", r, a, wd, pw, gr, rq_addr[w], rq_wdata[w], rq_wr[w], 2'(1 << w)); end
        n_checks++; if (st !== 1'b1 || gl !== 1'b0) begin n_fail++; $display("FAIL rnd_stable r%0d: got stable %b errglitch %b expected 1 0", r, st, gl); end
        exp_last = (w == 1);
        pend[w] = 1'b0;
        drive_req(w, 1'b0);
        if (pend != 2'b00) slave_cfg($urandom_range(0, 5), ($urandom_range(0, 3) == 0), $urandom);
      end
      tick();
    end
  endtask

  task automatic test_reset_in_access();
    int lat; logic [1:0] dn, er, gr; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] wd;
    logic pw, st, gl; bit ok, saw_done;
    set_cmd(0, 1'b1, $urandom, $urandom);
    slave_cfg(100, 1'b0, $urandom);
    drive_req(0, 1'b1);
    ok = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (PENABLE) begin ok = 1; break; end
    end
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rst_access_reach: got %b expected 1", ok); end
    PRESET = 1'b1;
    drive_req(0, 1'b0);
    tick();
    PRESET = 1'b0;
    n_checks++; if ({PSEL, PENABLE, PWRITE, grant} !== 5'b0) begin n_fail++; $display("FAIL rst_access_ctrl: got %b expected 00000", {PSEL, PENABLE, PWRITE, grant}); end
    n_checks++; if (PADDR !== '0 || PWDATA !== '0) begin n_fail++; $display("FAIL rst_access_bus: got %h %h expected 0", PADDR, PWDATA); end
    n_checks++; if (rdata0 !== '0 || rdata1 !== '0) begin n_fail++; $display("FAIL rst_access_rdata: got %h %h expected 0", rdata0, rdata1); end
    saw_done = ({done1, done0, err1, err0} != 4'b0);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done0 || done1) saw_done = 1;
    end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rst_access_nodone: got %b expected 0", saw_done); end
    exp_last = 1'b1; exp_rdata[0] = '0; exp_rdata[1] = '0;
    // pointer must be back at its reset value: a tie goes to port 0
    set_cmd(0, 1'b0, $urandom, $urandom);
    set_cmd(1, 1'b0, $urandom, $urandom);
    slave_cfg(0, 1'b0, $urandom);
    drive_req(0, 1'b1); drive_req(1, 1'b1);
    wait_done(lat, dn, er, gr, a, wd, pw, st, gl);
    n_checks++; if (dn !== 2'(1 << rr_pick(2'b11))) begin n_fail++; $display("FAIL rst_access_tie: got done %b expected %b", dn, 2'(1 << rr_pick(2'b11))); end
    drive_req(0, 1'b0); drive_req(1, 1'b0);
    tick();
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single_read();
    test_wait_states();
    test_timeout();
    test_slave_error();
    test_random();
    test_reset_in_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_uart_arbiter.md
APB_UART_ARBITER -- requirements
Module: apb_uart_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: APB address width.
REQ-002 Parameter DATA_W, default 32: APB data width.
REQ-003 Parameter TIMEOUT, default 16: max ACCESS cycles without PREADY before abort; 0 disables timeout.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset:
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  synchronous active-high reset
REQ-005 Requester ports, i in {0,1}:
- reqi  in  1  transfer request; held with command stable until donei
- wri  in  1  1=write, 0=read
- addri  in  ADDR_W  target address
- wdatai  in  DATA_W  write data
- donei  out  1  one-cycle completion pulse
- erri  out  1  valid with donei; 1=PSLVERR or timeout
- rdatai  out  DATA_W  read data, updated only on successful read completion
REQ-006 APB master-side ports:
- PSEL  out  1
- PENABLE  out  1
- PWRITE  out  1
- PADDR  out  ADDR_W
- PWDATA  out  DATA_W
- PRDATA  in  DATA_W
- PREADY  in  1
- PSLVERR  in  1
- grant  out  2  one-hot owner during SETUP/ACCESS, 00 otherwise

Function
REQ-007 FSM states SHALL be IDLE, SETUP, ACCESS.
REQ-008 IDLE: if any unmasked reqi=1, select a winner, latch its wr/addr/wdata into PWRITE/PADDR/PWDATA, and go to SETUP; else stay in IDLE.
REQ-009 Arbitration SHALL be round-robin: a single request wins outright; on a tie, the requester not served last wins; last-served pointer updates on every completion, including an errored one.
REQ-010 SETUP: PSEL=1, PENABLE=0, grant=winner; next state is always ACCESS.
REQ-011 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA SHALL stay stable from SETUP through the end of ACCESS.
REQ-012 ACCESS with PREADY=1: next cycle state=IDLE, PSEL=PENABLE=0, donei=1 for the winner, erri=PSLVERR, and rdatai=PRDATA if read with PSLVERR=0; otherwise rdatai holds.
REQ-013 Minimum latency: reqi sampled in IDLE at cycle N -> SETUP N+1 -> ACCESS N+2 -> donei at N+3 when PREADY=1 at N+2.
REQ-014 Wait states: PREADY=0 in ACCESS holds ACCESS; a wait counter increments per stalled cycle and clears on leaving ACCESS.
REQ-015 Timeout: if TIMEOUT>0 and PREADY=0 on the TIMEOUT-th ACCESS cycle, the transfer SHALL abort: next cycle PSEL=PENABLE=0, state IDLE, donei=1, erri=1, rdatai unchanged.
REQ-016 In the cycle donei=1 the block SHALL be in IDLE with reqi masked; a reqi still high on the following cycle is a new transfer.
REQ-017 Requests arriving during SETUP/ACCESS SHALL wait; none are dropped while held.
REQ-018 done0 and done1 SHALL never be high in the same cycle; erri=0 whenever donei=0.

Reset
REQ-019 PRESET=1 at a clock edge SHALL force: state IDLE; PSEL, PENABLE, PWRITE=0; PADDR, PWDATA=0; grant=00; done0/1, err0/1=0; rdata0/1=0; last-served pointer=1, so requester 0 wins the first tie.
REQ-020 Reset mid-transfer SHALL abort at once with no donei pulse; the requester re-issues.

Verification
REQ-021 Single read: req0 with addr0=0x10, PREADY=1 at ACCESS, PRDATA=0xDEADBEEF -> done0 at cycle N+3, err0=0, rdata0=0xDEADBEEF.
REQ-022 Tie after reset: req0 and req1 both high -> port 0 served first, then port 1; next tie serves port 0 (alternation).
REQ-023 Wait states: PREADY low for 3 ACCESS cycles, write wdata1=0x55 -> PADDR/PWDATA stable throughout; done1 4 cycles after ACCESS entry, err1=0.
REQ-024 Timeout: TIMEOUT=4, PREADY held 0 -> abort after the 4th ACCESS cycle: done0=1, err0=1, rdata0 unchanged, PSEL=0.
REQ-025 Slave error: read with PSLVERR=1 -> err=1, rdata unchanged.
REQ-026 Reset in ACCESS: PRESET pulsed -> all outputs at reset values next cycle, no done pulse.
